// File: rtl/alu_arbiter_if.sv
// ============================================================================
//  Module      : alu_arbiter_if
//  Description : Request/response channels of two ALU requesters plus the
//                shared-ALU operand and result bus.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu_arbiter_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int ALU_CTRL_WIDTH = 4
);
    logic                      req0_valid;
    logic                      req0_ready;
    logic [DATA_WIDTH-1:0]     req0_SrcA;
    logic [DATA_WIDTH-1:0]     req0_SrcB;
    logic [DATA_WIDTH-1:0]     req0_PC;
    logic [ALU_CTRL_WIDTH-1:0] req0_ALUControl;

    logic                      req1_valid;
    logic                      req1_ready;
    logic [DATA_WIDTH-1:0]     req1_SrcA;
    logic [DATA_WIDTH-1:0]     req1_SrcB;
    logic [DATA_WIDTH-1:0]     req1_PC;
    logic [ALU_CTRL_WIDTH-1:0] req1_ALUControl;

    logic                      resp0_valid;
    logic                      resp0_ready;
    logic [DATA_WIDTH-1:0]     resp0_result;
    logic                      resp0_zero;

    logic                      resp1_valid;
    logic                      resp1_ready;
    logic [DATA_WIDTH-1:0]     resp1_result;
    logic                      resp1_zero;

    logic [DATA_WIDTH-1:0]     SrcA;
    logic [DATA_WIDTH-1:0]     SrcB;
    logic [DATA_WIDTH-1:0]     PC;
    logic [ALU_CTRL_WIDTH-1:0] ALUControl;
    logic [DATA_WIDTH-1:0]     ALUResult;
    logic                      Zero;

    // Requesters and the shared ALU sit on the master side.
    modport master (
        output req0_valid, req0_SrcA, req0_SrcB, req0_PC, req0_ALUControl,
        output req1_valid, req1_SrcA, req1_SrcB, req1_PC, req1_ALUControl,
        output resp0_ready, resp1_ready, ALUResult, Zero,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp0_result, resp0_zero,
        input  resp1_valid, resp1_result, resp1_zero,
        input  SrcA, SrcB, PC, ALUControl
    );

    modport slave (
        input  req0_valid, req0_SrcA, req0_SrcB, req0_PC, req0_ALUControl,
        input  req1_valid, req1_SrcA, req1_SrcB, req1_PC, req1_ALUControl,
        input  resp0_ready, resp1_ready, ALUResult, Zero,
        output req0_ready, req1_ready,
        output resp0_valid, resp0_result, resp0_zero,
        output resp1_valid, resp1_result, resp1_zero,
        output SrcA, SrcB, PC, ALUControl
    );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
//  Module      : alu_arbiter
//  Description : Round-robin arbiter sharing one combinational ALU between two
//                requesters, with a one-deep response register per port.
//                Define ALU_ARB_FIXED_PRIO_EN for fixed port-0 priority.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ALU_CTRL_WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);
    logic                      w_elig0;
    logic                      w_elig1;
    logic                      w_grant0;
    logic                      w_grant1;
    logic [DATA_WIDTH-1:0]     w_srca;
    logic [DATA_WIDTH-1:0]     w_srcb;
    logic [DATA_WIDTH-1:0]     w_pc;
    logic [ALU_CTRL_WIDTH-1:0] w_ctrl;

    logic                      r_resp0_valid;
    logic                      r_resp1_valid;
    logic [DATA_WIDTH-1:0]     r_resp0_result;
    logic [DATA_WIDTH-1:0]     r_resp1_result;
    logic                      r_resp0_zero;
    logic                      r_resp1_zero;

    // A port may issue when its slot is empty or being drained this cycle.
    assign w_elig0 = bus.req0_valid && (!r_resp0_valid || bus.resp0_ready);
    assign w_elig1 = bus.req1_valid && (!r_resp1_valid || bus.resp1_ready);

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign w_grant0 = !rst && w_elig0;
    assign w_grant1 = !rst && w_elig1 && !w_elig0;
`else
    // 1 means port 1 was granted last, so port 0 wins the next tie.
    logic r_last_grant;

    assign w_grant0 = !rst && w_elig0 && (!w_elig1 || r_last_grant);
    assign w_grant1 = !rst && w_elig1 && (!w_elig0 || !r_last_grant);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (w_grant0) begin
            r_last_grant <= 1'b0;
        end else if (w_grant1) begin
            r_last_grant <= 1'b1;
        end
    end
`endif

    always_comb begin
        w_srca = '0;
        w_srcb = '0;
        w_pc   = '0;
        w_ctrl = '0;
        if (w_grant0) begin
            w_srca = bus.req0_SrcA;
            w_srcb = bus.req0_SrcB;
            w_pc   = bus.req0_PC;
            w_ctrl = bus.req0_ALUControl;
        end else if (w_grant1) begin
            w_srca = bus.req1_SrcA;
            w_srcb = bus.req1_SrcB;
            w_pc   = bus.req1_PC;
            w_ctrl = bus.req1_ALUControl;
        end
    end

    // A grant refills the slot even when it is drained in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp0_valid  <= 1'b0;
            r_resp0_result <= '0;
            r_resp0_zero   <= 1'b0;
            r_resp1_valid  <= 1'b0;
            r_resp1_result <= '0;
            r_resp1_zero   <= 1'b0;
        end else begin
            if (w_grant0) begin
                r_resp0_valid  <= 1'b1;
                r_resp0_result <= bus.ALUResult;
                r_resp0_zero   <= bus.Zero;
            end else if (bus.resp0_ready) begin
                r_resp0_valid  <= 1'b0;
            end
            if (w_grant1) begin
                r_resp1_valid  <= 1'b1;
                r_resp1_result <= bus.ALUResult;
                r_resp1_zero   <= bus.Zero;
            end else if (bus.resp1_ready) begin
                r_resp1_valid  <= 1'b0;
            end
        end
    end

    assign bus.req0_ready   = w_grant0;
    assign bus.req1_ready   = w_grant1;
    assign bus.SrcA         = w_srca;
    assign bus.SrcB         = w_srcb;
    assign bus.PC           = w_pc;
    assign bus.ALUControl   = w_ctrl;
    assign bus.resp0_valid  = r_resp0_valid;
    assign bus.resp0_result = r_resp0_result;
    assign bus.resp0_zero   = r_resp0_zero;
    assign bus.resp1_valid  = r_resp1_valid;
    assign bus.resp1_result = r_resp1_result;
    assign bus.resp1_zero   = r_resp1_zero;
endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Directed, table-driven bench for alu_arbiter with a small
//                reference ALU on the shared bus.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;
    localparam int DW = 32;
`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef struct {
        logic        v0; logic [3:0] c0; logic [31:0] a0; logic [31:0] b0; logic [31:0] pc0;
        logic        v1; logic [3:0] c1; logic [31:0] a1; logic [31:0] b1; logic [31:0] pc1;
        logic        rr0; logic rr1;
        logic        g0;  logic g1;
        logic [31:0] e_a; logic [3:0] e_c; logic [31:0] e_pc;
        logic        rv0; logic [31:0] r0; logic z0;
        logic        rv1; logic [31:0] r1; logic z1;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [31:0] alu_res;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n0, n1;
    logic e0;
    vec_t tbl[$];

    alu_arbiter_if #(.DATA_WIDTH(DW), .ALU_CTRL_WIDTH(4)) bus ();

    alu_arbiter #(.DATA_WIDTH(DW), .ALU_CTRL_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference ALU: only the op codes exercised here.
    always_comb begin
        case (bus.ALUControl)
            4'b0000: alu_res = bus.SrcA + bus.SrcB;
            4'b0001: alu_res = bus.SrcA - bus.SrcB;
            4'b1011: alu_res = bus.SrcB << 12;
            4'b1100: alu_res = bus.PC + 32'd4;
            4'b1010: alu_res = bus.PC + (bus.SrcB << 12);
            default: alu_res = '0;
        endcase
        bus.ALUResult = alu_res;
        bus.Zero      = (alu_res == '0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_req0(input logic v, input logic [3:0] c, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] pc);
        bus.req0_valid = v; bus.req0_ALUControl = c;
        bus.req0_SrcA  = a; bus.req0_SrcB = b; bus.req0_PC = pc;
    endtask

    task automatic set_req1(input logic v, input logic [3:0] c, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] pc);
        bus.req1_valid = v; bus.req1_ALUControl = c;
        bus.req1_SrcA  = a; bus.req1_SrcB = b; bus.req1_PC = pc;
    endtask

    initial begin
        // Single add, zero/LUI on port 1, PC-relative ops, then backpressure.
        tbl.push_back('{1,4'h0,5,7,0,            0,4'h0,0,0,0,              1,1, 1,0, 5,4'h0,0,        1,12,0,          0,0,0});
        tbl.push_back('{0,4'h0,0,0,0,            0,4'h0,0,0,0,              1,1, 0,0, 0,4'h0,0,        0,12,0,          0,0,0});
        tbl.push_back('{0,4'h0,0,0,0,            1,4'h1,9,9,0,              1,1, 0,1, 9,4'h1,0,        0,12,0,          1,0,1});
        tbl.push_back('{0,4'h0,0,0,0,            1,4'hb,0,32'h12345,0,      1,1, 0,1, 0,4'hb,0,        0,12,0,          1,32'h12345000,0});
        tbl.push_back('{0,4'h0,0,0,0,            0,4'h0,0,0,0,              1,1, 0,0, 0,4'h0,0,        0,12,0,          0,32'h12345000,0});
        tbl.push_back('{1,4'hc,0,0,32'h100,      0,4'h0,0,0,0,              1,1, 1,0, 0,4'hc,32'h100,  1,32'h104,0,     0,32'h12345000,0});
        tbl.push_back('{1,4'ha,0,1,32'h100,      0,4'h0,0,0,0,              1,1, 1,0, 0,4'ha,32'h100,  1,32'h1100,0,    0,32'h12345000,0});
        tbl.push_back('{0,4'h0,0,0,0,            0,4'h0,0,0,0,              1,1, 0,0, 0,4'h0,0,        0,32'h1100,0,    0,32'h12345000,0});
        tbl.push_back('{1,4'h0,10,1,0,           0,4'h0,0,0,0,              0,1, 1,0, 10,4'h0,0,       1,11,0,          0,32'h12345000,0});
        tbl.push_back('{1,4'h0,3,4,0,            1,4'h0,20,2,0,             0,1, 0,1, 20,4'h0,0,       1,11,0,          1,22,0});
        tbl.push_back('{1,4'h0,3,4,0,            1,4'h0,30,3,0,             0,1, 0,1, 30,4'h0,0,       1,11,0,          1,33,0});
        tbl.push_back('{1,4'h0,3,4,0,            1,4'h0,40,4,0,             1,1, 1,0, 3,4'h0,0,        1,7,0,           0,33,0});
        tbl.push_back('{1,4'h0,1,1,0,            1,4'h0,40,4,0,             1,1, FIXED,!FIXED, FIXED ? 32'd1 : 32'd40, 4'h0, 0,
                        FIXED, FIXED ? 32'd2 : 32'd7, 0,                    !FIXED, FIXED ? 32'd33 : 32'd44, 0});
        tbl.push_back('{0,4'h0,0,0,0,            0,4'h0,0,0,0,              1,1, 0,0, 0,4'h0,0,
                        0, FIXED ? 32'd2 : 32'd7, 0,                        0, FIXED ? 32'd33 : 32'd44, 0});

        // Reset, with a request already pending that must not be granted.
        rst = 1'b1;
        set_req0(1, 4'h0, 5, 7, 0);
        set_req1(1, 4'h0, 1, 1, 0);
        bus.resp0_ready = 1'b0;
        bus.resp1_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst req0_ready", 32'(bus.req0_ready), 0);
        chk("rst req1_ready", 32'(bus.req1_ready), 0);
        chk("rst resp0_valid", 32'(bus.resp0_valid), 0);
        chk("rst resp1_valid", 32'(bus.resp1_valid), 0);
        chk("rst resp0_result", bus.resp0_result, 0);
        chk("rst resp1_result", bus.resp1_result, 0);
        chk("rst resp0_zero", 32'(bus.resp0_zero), 0);
        chk("rst SrcA", bus.SrcA, 0);
        @(negedge clk);
        rst = 1'b0;
        set_req0(0, 4'h0, 0, 0, 0);
        set_req1(0, 4'h0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            set_req0(tbl[i].v0, tbl[i].c0, tbl[i].a0, tbl[i].b0, tbl[i].pc0);
            set_req1(tbl[i].v1, tbl[i].c1, tbl[i].a1, tbl[i].b1, tbl[i].pc1);
            bus.resp0_ready = tbl[i].rr0;
            bus.resp1_ready = tbl[i].rr1;
            #1;
            chk($sformatf("v%0d req0_ready", i), 32'(bus.req0_ready), 32'(tbl[i].g0));
            chk($sformatf("v%0d req1_ready", i), 32'(bus.req1_ready), 32'(tbl[i].g1));
            chk($sformatf("v%0d SrcA", i), bus.SrcA, tbl[i].e_a);
            chk($sformatf("v%0d ALUControl", i), 32'(bus.ALUControl), 32'(tbl[i].e_c));
            chk($sformatf("v%0d PC", i), bus.PC, tbl[i].e_pc);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d resp0_valid", i), 32'(bus.resp0_valid), 32'(tbl[i].rv0));
            chk($sformatf("v%0d resp0_result", i), bus.resp0_result, tbl[i].r0);
            chk($sformatf("v%0d resp0_zero", i), 32'(bus.resp0_zero), 32'(tbl[i].z0));
            chk($sformatf("v%0d resp1_valid", i), 32'(bus.resp1_valid), 32'(tbl[i].rv1));
            chk($sformatf("v%0d resp1_result", i), bus.resp1_result, tbl[i].r1);
            chk($sformatf("v%0d resp1_zero", i), 32'(bus.resp1_zero), 32'(tbl[i].z1));
        end

        // Reset asserted in the response cycle discards the pending result.
        @(negedge clk);
        set_req0(1, 4'h0, 1, 1, 0);
        bus.resp0_ready = 1'b0;
        #1;
        chk("midrst grant", 32'(bus.req0_ready), 1);
        @(negedge clk);
        set_req0(0, 4'h0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk("midrst resp0_valid before", 32'(bus.resp0_valid), 1);
        chk("midrst resp0_result before", bus.resp0_result, 2);
        @(posedge clk);
        #1;
        chk("midrst resp0_valid after", 32'(bus.resp0_valid), 0);
        chk("midrst resp0_result after", bus.resp0_result, 0);
        @(negedge clk);
        rst = 1'b0;

        // Four-cycle tie with responses always consumed.
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < 4; k++) begin
            e0 = FIXED ? 1'b1 : (k % 2 == 0);
            @(negedge clk);
            set_req0(1, 4'h0, 32'(100 + n0), 0, 0);
            set_req1(1, 4'h0, 32'(200 + n1), 0, 0);
            bus.resp0_ready = 1'b1;
            bus.resp1_ready = 1'b1;
            #1;
            chk($sformatf("tie%0d req0_ready", k), 32'(bus.req0_ready), 32'(e0));
            chk($sformatf("tie%0d req1_ready", k), 32'(bus.req1_ready), 32'(!e0));
            @(posedge clk);
            #1;
            if (e0) begin
                chk($sformatf("tie%0d resp0_valid", k), 32'(bus.resp0_valid), 1);
                chk($sformatf("tie%0d resp0_result", k), bus.resp0_result, 32'(100 + n0));
                n0++;
            end else begin
                chk($sformatf("tie%0d resp1_valid", k), 32'(bus.resp1_valid), 1);
                chk($sformatf("tie%0d resp1_result", k), bus.resp1_result, 32'(200 + n1));
                n1++;
            end
        end
        @(negedge clk);
        set_req0(0, 4'h0, 0, 0, 0);
        set_req1(0, 4'h0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("final resp0_valid", 32'(bus.resp0_valid), 0);
        chk("final resp1_valid", 32'(bus.resp1_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
